// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues in-order word requests, buffers (pc, instr)
// pairs in a small FIFO and hands them to decode; redirects flush and drop stale responses.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000,
    parameter int               DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             fetch_o_valid,
    output logic [WIDTH-1:0] fetch_o_instr,
    output logic [WIDTH-1:0] fetch_o_pc,
    input  logic             decode_i_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);

    logic [WIDTH-1:0] req_pc_reg, req_pc_next;
    logic [WIDTH-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [CW-1:0]    outstanding_reg, outstanding_next;
    logic [CW-1:0]    drop_reg, drop_next;
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [CW:0]      in_use;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] redirect_target;

    // FIFO slots are reserved when a request is issued, so in-flight requests
    // count against capacity and a kept response can always be pushed.
    assign in_use          = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign imem_req_valid  = !rst && !redirect_i && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr   = req_pc_reg;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = redirect_pc_i & ~WIDTH'(3);

    assign push = imem_rsp_valid && (drop_reg == '0) && !redirect_i;
    assign pop  = fetch_o_valid && decode_i_ready && !redirect_i;

    assign fetch_o_valid = (count_reg != '0);
    assign fetch_o_instr = fetch_o_valid ? instr_mem[rd_ptr_reg] : NOP_INSTR;
    assign fetch_o_pc    = fetch_o_valid ? pc_mem[rd_ptr_reg]    : '0;

    always_comb begin
        req_pc_next      = req_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        count_next       = count_reg;
        drop_next        = drop_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect_i) begin
            // Every response still in flight after this cycle belongs to the old path.
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            req_pc_next = redirect_target;
            rsp_pc_next = redirect_target;
            drop_next   = outstanding_reg - CW'(imem_rsp_valid);
        end else begin
            count_next  = count_reg + CW'(push) - CW'(pop);
            wr_ptr_next = wr_ptr_reg + AW'(push);
            rd_ptr_next = rd_ptr_reg + AW'(pop);
            if (req_fire) begin
                req_pc_next = req_pc_reg + PC_STEP;
            end
            if (push) begin
                rsp_pc_next = rsp_pc_reg + PC_STEP;
            end
            if (imem_rsp_valid && (drop_reg != '0)) begin
                drop_next = drop_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_reg      <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            req_pc_reg      <= req_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
            instr_mem[wr_ptr_reg] <= imem_rsp_data;
        end
    end
endmodule
